// File: rtl/rr_resource_controller.sv
`default_nettype none
// ============================================================================
// Module   : rr_resource_controller
// Purpose  : Round-robin owner controller for one shared resource. Grants a
//            single requester at a time, keeps the grant until the owner
//            signals done, drops its request, or exhausts the hold budget,
//            then inserts exactly one dead (GAP) cycle before the next owner.
// Ports    : clk, rst_n (async active-low)
//            requesters[NUM_REQUESTERS] : per-requester request level
//            done[NUM_REQUESTERS]       : per-requester end-of-transaction pulse
//            grant[NUM_REQUESTERS]      : registered one-hot grant (or zero)
//            owner_id[ID_W]             : registered index of the owner
//            busy                       : high while a grant is held
//            timeout                    : high in the GAP after a forced release
// Revision : 1.0 - initial release
// ============================================================================
module rr_resource_controller #(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int MAX_HOLD       = 16,
    localparam int ID_W           = $clog2(NUM_REQUESTERS),
    localparam int CNT_W          = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQUESTERS-1:0] requesters,
    input  logic [NUM_REQUESTERS-1:0] done,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [ID_W-1:0]           owner_id,
    output logic                      busy,
    output logic                      timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [NUM_REQUESTERS-1:0] ONE       = NUM_REQUESTERS'(1);
    localparam logic [CNT_W-1:0]          HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t                    state, state_n;
    logic [NUM_REQUESTERS-1:0] last, last_n;
    logic [NUM_REQUESTERS-1:0] grant_n;
    logic [ID_W-1:0]           owner_id_n;
    logic [CNT_W-1:0]          hold_cnt, hold_cnt_n;
    logic                      timeout_n;

    logic [NUM_REQUESTERS-1:0] masked;
    logic [NUM_REQUESTERS-1:0] cand;
    logic [NUM_REQUESTERS-1:0] winner;
    logic [ID_W-1:0]           winner_id;
    logic                      owner_done;
    logic                      owner_req;
    logic                      at_limit;

    // ------------------------------------------------------------------------
    // Arbitration. (last-1)|last covers every bit at or below the previous
    // owner, so masked keeps only requesters strictly above it. With last=0
    // the subtraction yields all ones and the search falls back to the plain
    // lowest-index requester, which is also the wrap-around case.
    // ------------------------------------------------------------------------
    always_comb begin
        masked    = requesters & ~((last - ONE) | last);
        cand      = (masked != '0) ? masked : requesters;
        winner    = cand & (~cand + ONE);   // isolate lowest set bit
        winner_id = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (winner[i]) begin
                winner_id = ID_W'(i);
            end
        end
    end

    // Owner-qualified views: done and request bits of non-owners are ignored.
    assign owner_done = |(done & grant);
    assign owner_req  = |(requesters & grant);
    assign at_limit   = (hold_cnt == HOLD_LAST);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        owner_id_n = owner_id;
        last_n     = last;
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;

        case (state)
            ST_IDLE, ST_GAP: begin
                if (requesters != '0) begin
                    state_n    = ST_OWN;
                    grant_n    = winner;
                    owner_id_n = winner_id;
                    last_n     = winner;
                    hold_cnt_n = '0;
                end else begin
                    state_n    = ST_IDLE;
                    grant_n    = '0;
                    owner_id_n = '0;
                end
            end

            ST_OWN: begin
                // A normal release outranks the budget check, so done on the
                // final allowed cycle never raises timeout.
                if (owner_done || !owner_req) begin
                    state_n    = ST_GAP;
                    grant_n    = '0;
                    owner_id_n = '0;
                end else if (at_limit) begin
                    state_n    = ST_GAP;
                    grant_n    = '0;
                    owner_id_n = '0;
                    timeout_n  = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n    = ST_IDLE;
                grant_n    = '0;
                owner_id_n = '0;
                last_n     = '0;
                hold_cnt_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner_id <= '0;
            last     <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner_id <= owner_id_n;
            last     <= last_n;
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end

    assign busy = (state == ST_OWN);

endmodule
`default_nettype wire

// File: tb/tb_rr_resource_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_resource_controller
// Purpose  : Self-checking bench for rr_resource_controller (4 requesters,
//            hold budget 16) with a behavioural owner/pointer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_resource_controller;

    localparam int N   = 4;
    localparam int MH  = 16;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   requesters;
    logic [N-1:0]   done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] owner_id;
    logic           busy;
    logic           timeout;

    int total = 0;
    int bad   = 0;

    rr_resource_controller #(.NUM_REQUESTERS(N), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .requesters (requesters),
        .done       (done),
        .grant      (grant),
        .owner_id   (owner_id),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Owner index (-1 = none), last owner index (-1 = none), cycles held.
    int m_owner   = -1;
    int m_last    = -1;
    int m_cnt     = 0;
    bit m_timeout = 1'b0;

    // First requester circularly after 'last'; from index 0 when last is none.
    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k + N) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = -1; m_cnt = 0; m_timeout = 1'b0;
        end else if (m_owner < 0) begin
            m_timeout = 1'b0;
            if (requesters != '0) begin
                m_owner = pick(requesters, m_last);
                m_last  = m_owner;
                m_cnt   = 1;
            end
        end else begin
            if (done[m_owner] || !requesters[m_owner]) begin
                m_owner = -1; m_timeout = 1'b0;
            end else if (m_cnt >= MH) begin
                m_owner = -1; m_timeout = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    function automatic logic [N+IDW+1:0] model_vec();
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        logic           b;
        g = '0; id = '0; b = 1'b0;
        if (m_owner >= 0) begin
            g  = N'(1) << m_owner;
            id = IDW'(m_owner);
            b  = 1'b1;
        end
        return {g, id, b, m_timeout};
    endfunction

    wire [N+IDW+1:0] obs = {grant, owner_id, busy, timeout};

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        requesters = r;
        done       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; requesters = '0; done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; requesters = 4'b1111; done = '0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_hold got=%b want=0", obs);
        end
        @(negedge clk);
        requesters = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_cycle('0, '0);
            total++;
            if (obs !== '0 || model_vec() !== '0) begin
                bad++; $display("FAIL reset_idle cyc=%0d got=%b want=0", c, obs);
            end
        end
    endtask

    task automatic test_single_owner();
        logic [N-1:0] gr[12];
        int run = 0;
        bit saw_to = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            run = (grant == 4'b0001) ? run + 1 : 0;
            drive_cycle(4'b0001, (run == 3) ? 4'b0001 : 4'b0000);
            gr[c] = grant;
            if (timeout) saw_to = 1;
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL single_model cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
        end
        total++;
        if ({gr[0], gr[1], gr[2], gr[3], gr[4]} !== {4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001}) begin
            bad++; $display("FAIL single_seq got=%b %b %b %b %b want=0001 0001 0001 0000 0001",
                            gr[0], gr[1], gr[2], gr[3], gr[4]);
        end
        total++;
        if (saw_to !== 1'b0) begin
            bad++; $display("FAIL single_timeout got=%b want=0", saw_to);
        end
    endtask

    task automatic test_rotation();
        int starts[$];
        logic [N-1:0] prev = '0;
        int run = 0;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            logic [N-1:0] want;
            run = (grant != '0) ? run + 1 : 0;
            drive_cycle(4'b1111, (run == 2) ? grant : 4'b0000);
            if (grant != '0 && prev == '0) starts.push_back(int'(owner_id));
            prev = grant;
            want = (c % 3 == 2) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
            total++;
            if (grant !== want || obs !== model_vec()) begin
                bad++; $display("FAIL rotation cyc=%0d grant=%b want=%b vec=%b model=%b",
                                c, grant, want, obs, model_vec());
            end
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= starts.size() || starts[k] != k % 4) begin
                bad++; $display("FAIL rotation_id k=%0d got=%0d want=%0d",
                                k, (k < starts.size()) ? starts[k] : -1, k % 4);
            end
        end
    endtask

    task automatic test_timeout(input bit with_done);
        logic [N-1:0] gr[20];
        logic         to[20];
        int run = 0;
        int lead = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            run = (grant == 4'b0001) ? run + 1 : 0;
            drive_cycle(4'b0101, (with_done && run == MH) ? 4'b0001 : 4'b0000);
            gr[c] = grant; to[c] = timeout;
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL timeout_model d=%0d cyc=%0d got=%b want=%b",
                                with_done, c, obs, model_vec());
            end
        end
        while (lead < 20 && gr[lead] == 4'b0001) lead++;
        total++;
        if (lead != MH) begin
            bad++; $display("FAIL timeout_len d=%0d got=%0d want=%0d", with_done, lead, MH);
        end
        total++;
        if (gr[16] !== 4'b0000 || to[16] !== !with_done || gr[17] !== 4'b0100 || to[17] !== 1'b0) begin
            bad++; $display("FAIL timeout_gap d=%0d got=%b/%b %b/%b want=0000/%b 0100/0",
                            with_done, gr[16], to[16], gr[17], to[17], !with_done);
        end
    endtask

    task automatic test_drop_stray();
        logic [N-1:0] rq[5] = '{4'b0100, 4'b0110, 4'b0010, 4'b0010, 4'b0010};
        logic [N-1:0] dn[5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [N-1:0] wg[5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(rq[c], dn[c]);
            total++;
            if (grant !== wg[c] || obs !== model_vec()) begin
                bad++; $display("FAIL drop_stray cyc=%0d grant=%b want=%b vec=%b model=%b",
                                c, grant, wg[c], obs, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) drive_cycle(4'b0100, 4'b0000);
        total++;
        if (grant !== 4'b0100) begin
            bad++; $display("FAIL reset_mid_pre got=%b want=0100", grant);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_mid_async got=%b want=0", obs);
        end
        @(negedge clk);
        requesters = 4'b1100;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (grant !== 4'b0100 || owner_id !== 2'd2 || obs !== model_vec()) begin
            bad++; $display("FAIL reset_mid_regrant got=%b want=0100 vec=%b model=%b",
                            grant, obs, model_vec());
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r = '0;
        logic [N-1:0] d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            d = '0;
            if ($urandom_range(0, 9) == 0) d = grant;
            if ($urandom_range(0, 7) == 0) d = d | N'($urandom);
            drive_cycle(r, d);
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL random cyc=%0d req=%b done=%b got=%b want=%b",
                                c, r, d, obs, model_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; requesters = '0; done = '0;
        test_reset();
        test_single_owner();
        test_rotation();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_drop_stray();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
